// File: rtl/rob_smt2_pkg.sv
// Shared constants and entry type for the dual-thread reorder buffer.
package rob_smt2_pkg;

    localparam int ROB_SIZE  = 16;
    localparam int PRF_SIZE  = 64;
    localparam int IDX_W     = $clog2(ROB_SIZE);
    localparam int ROB_IDX_W = IDX_W + 1;
    localparam int PRN_W     = $clog2(PRF_SIZE);
    localparam int CNT_W     = IDX_W + 1;

    typedef struct packed {
        logic             valid;
        logic             executed;
        logic [63:0]      pc;
        logic [63:0]      target_pc;
        logic [4:0]       arn;
        logic [PRN_W-1:0] prn;
        logic             branch;
        logic             mispredict;
        logic             halt;
        logic             illegal;
    } rob_entry_t;

    // A flush is only triggered by a branch that resolved the wrong way.
    function automatic logic is_mispredicted(rob_entry_t e);
        return e.branch & e.mispredict;
    endfunction

endpackage

// File: rtl/rob_thread_queue.sv
// Per-thread circular reorder queue: allocate at tail, complete by index, retire from head.
// Optional macro ROB_ASSERT_EN adds a simulation check on completions to invalid entries.
module rob_thread_queue
    import rob_smt2_pkg::*;
#(
    parameter logic THREAD_ID = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc1,
    input  logic                 alloc2,
    input  rob_entry_t           new1,
    input  rob_entry_t           new2,
    input  logic                 comp1_valid,
    input  logic [ROB_IDX_W-1:0] comp1_idx,
    input  logic                 comp1_mispredict,
    input  logic [63:0]          comp1_target,
    input  logic                 comp2_valid,
    input  logic [ROB_IDX_W-1:0] comp2_idx,
    input  logic                 comp2_mispredict,
    input  logic [63:0]          comp2_target,
    input  logic [1:0]           retire_cnt,
    input  logic                 flush,
    output logic [IDX_W-1:0]     tail,
    output logic                 is_full,
    output rob_entry_t           head_entry,
    output rob_entry_t           next_entry
);

    rob_entry_t       entries_q [ROB_SIZE];
    logic [IDX_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    logic [IDX_W-1:0] head_p1, tail_p1, slot1, slot2;
    logic             comp1_hit, comp2_hit;

    // Decode pointers and which completion ports address a live entry of this thread.
    always_comb begin
        head_p1    = head_q + IDX_W'(1);
        tail_p1    = tail_q + IDX_W'(1);
        slot1      = comp1_idx[IDX_W-1:0];
        slot2      = comp2_idx[IDX_W-1:0];
        comp1_hit  = comp1_valid && (comp1_idx[IDX_W] == THREAD_ID) && entries_q[slot1].valid;
        comp2_hit  = comp2_valid && (comp2_idx[IDX_W] == THREAD_ID) && entries_q[slot2].valid;
        tail       = tail_q;
        is_full    = count_q >= CNT_W'(ROB_SIZE - 1);
        head_entry = entries_q[head_q];
        next_entry = entries_q[head_p1];
    end

    // Queue state update; port 2 completion is written last so it wins on a shared index.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_q[i].valid    <= 1'b0;
                entries_q[i].executed <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (comp1_hit) begin
                entries_q[slot1].executed   <= 1'b1;
                entries_q[slot1].mispredict <= comp1_mispredict;
                entries_q[slot1].target_pc  <= comp1_target;
            end
            if (comp2_hit) begin
                entries_q[slot2].executed   <= 1'b1;
                entries_q[slot2].mispredict <= comp2_mispredict;
                entries_q[slot2].target_pc  <= comp2_target;
            end
            if (retire_cnt != 2'd0) entries_q[head_q].valid <= 1'b0;
            if (retire_cnt == 2'd2) entries_q[head_p1].valid <= 1'b0;
            if (alloc1) entries_q[tail_q] <= new1;
            if (alloc2) entries_q[alloc1 ? tail_p1 : tail_q] <= new2;
            head_q  <= head_q + IDX_W'(retire_cnt);
            tail_q  <= tail_q + IDX_W'(alloc1) + IDX_W'(alloc2);
            count_q <= count_q + CNT_W'(alloc1) + CNT_W'(alloc2) - CNT_W'(retire_cnt);
        end
    end

`ifdef ROB_ASSERT_EN
    // Completions must only target entries that are currently allocated.
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(comp1_valid && comp1_idx[IDX_W] == THREAD_ID && !entries_q[slot1].valid))
                else $error("completion port 1 to invalid entry");
            assert (!(comp2_valid && comp2_idx[IDX_W] == THREAD_ID && !entries_q[slot2].valid))
                else $error("completion port 2 to invalid entry");
        end
    end
`else
`endif

endmodule

// File: rtl/rob_smt2.sv
// Dual-thread, 2-wide reorder buffer: dispatch, completion and in-order 2-wide commit.
// Optional macro ROB_ASSERT_EN enables simulation assertions (load while full, X on valids).
module rob_smt2
    import rob_smt2_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 is_thread1,
    input  logic [63:0]          inst1_pc_in,
    input  logic [4:0]           inst1_arn_dest_in,
    input  logic [PRN_W-1:0]     inst1_prn_dest_in,
    input  logic                 inst1_is_branch_in,
    input  logic                 inst1_is_halt_in,
    input  logic                 inst1_is_illegal_in,
    input  logic                 inst1_load_in,
    input  logic [63:0]          inst2_pc_in,
    input  logic [4:0]           inst2_arn_dest_in,
    input  logic [PRN_W-1:0]     inst2_prn_dest_in,
    input  logic                 inst2_is_branch_in,
    input  logic                 inst2_is_halt_in,
    input  logic                 inst2_is_illegal_in,
    input  logic                 inst2_load_in,
    input  logic                 if_fu_executed1,
    input  logic [ROB_IDX_W-1:0] fu_rob_idx1,
    input  logic                 mispredict_in1,
    input  logic [63:0]          target_pc_in1,
    input  logic                 if_fu_executed2,
    input  logic [ROB_IDX_W-1:0] fu_rob_idx2,
    input  logic                 mispredict_in2,
    input  logic [63:0]          target_pc_in2,
    output logic [ROB_IDX_W-1:0] inst1_rs_rob_idx_in,
    output logic [ROB_IDX_W-1:0] inst2_rs_rob_idx_in,
    output logic [63:0]          commit1_pc_out,
    output logic [63:0]          commit1_target_pc_out,
    output logic                 commit1_is_branch_out,
    output logic                 commit1_mispredict_out,
    output logic                 commit1_is_halt_out,
    output logic                 commit1_is_illegal_out,
    output logic [4:0]           commit1_arn_dest_out,
    output logic [PRN_W-1:0]     commit1_prn_dest_out,
    output logic                 commit1_if_rename_out,
    output logic                 commit1_valid,
    output logic                 commit1_is_thread1,
    output logic [63:0]          commit2_pc_out,
    output logic [63:0]          commit2_target_pc_out,
    output logic                 commit2_is_branch_out,
    output logic                 commit2_mispredict_out,
    output logic                 commit2_is_halt_out,
    output logic                 commit2_is_illegal_out,
    output logic [4:0]           commit2_arn_dest_out,
    output logic [PRN_W-1:0]     commit2_prn_dest_out,
    output logic                 commit2_if_rename_out,
    output logic                 commit2_valid,
    output logic                 commit2_is_thread1,
    output logic                 t1_is_full,
    output logic                 t2_is_full
);

    rob_entry_t       new1, new2;
    rob_entry_t       t1_head, t1_next, t2_head, t2_next;
    rob_entry_t       e1, e2;
    logic [IDX_W-1:0] t1_tail, t2_tail, sel_tail;
    logic             load_ok;
    logic             t1_alloc1, t1_alloc2, t2_alloc1, t2_alloc2;
    logic             sel_t1, c1, c2, flush_sel;
    logic [1:0]       retire_cnt, t1_retire, t2_retire;
    logic             t1_flush, t2_flush;

    // Build new entries and steer the dispatch pair to the selected thread.
    always_comb begin
        new1 = '{valid: 1'b1, executed: inst1_is_halt_in | inst1_is_illegal_in,
                 pc: inst1_pc_in, target_pc: 64'd0, arn: inst1_arn_dest_in,
                 prn: inst1_prn_dest_in, branch: inst1_is_branch_in, mispredict: 1'b0,
                 halt: inst1_is_halt_in, illegal: inst1_is_illegal_in};
        new2 = '{valid: 1'b1, executed: inst2_is_halt_in | inst2_is_illegal_in,
                 pc: inst2_pc_in, target_pc: 64'd0, arn: inst2_arn_dest_in,
                 prn: inst2_prn_dest_in, branch: inst2_is_branch_in, mispredict: 1'b0,
                 halt: inst2_is_halt_in, illegal: inst2_is_illegal_in};
        load_ok   = is_thread1 ? !t1_is_full : !t2_is_full;
        t1_alloc1 = inst1_load_in & is_thread1 & load_ok;
        t1_alloc2 = inst2_load_in & is_thread1 & load_ok;
        t2_alloc1 = inst1_load_in & !is_thread1 & load_ok;
        t2_alloc2 = inst2_load_in & !is_thread1 & load_ok;
        sel_tail  = is_thread1 ? t1_tail : t2_tail;
        // A lone slot-2 load takes the tail itself.
        inst1_rs_rob_idx_in = {!is_thread1, sel_tail};
        inst2_rs_rob_idx_in = {!is_thread1,
                               (inst1_load_in || !inst2_load_in) ? sel_tail + IDX_W'(1) : sel_tail};
    end

    // Pick the retiring thread and decide how many of its head entries leave this cycle.
    always_comb begin
        sel_t1     = t1_head.valid & t1_head.executed;
        e1         = sel_t1 ? t1_head : t2_head;
        e2         = sel_t1 ? t1_next : t2_next;
        c1         = sel_t1 | (t2_head.valid & t2_head.executed);
        c2         = c1 & e2.valid & e2.executed & !(e1.halt | e1.illegal | is_mispredicted(e1));
        flush_sel  = (c1 & is_mispredicted(e1)) | (c2 & is_mispredicted(e2));
        retire_cnt = {1'b0, c1} + {1'b0, c2};
        t1_retire  = sel_t1 ? retire_cnt : 2'd0;
        t2_retire  = sel_t1 ? 2'd0 : retire_cnt;
        t1_flush   = sel_t1 & flush_sel;
        t2_flush   = !sel_t1 & flush_sel;
    end

    // Commit outputs are forced to zero for slots that do not retire.
    always_comb begin
        commit1_valid          = c1;
        commit1_if_rename_out  = c1;
        commit1_is_thread1     = c1 & sel_t1;
        commit1_pc_out         = c1 ? e1.pc : 64'd0;
        commit1_target_pc_out  = c1 ? e1.target_pc : 64'd0;
        commit1_is_branch_out  = c1 & e1.branch;
        commit1_mispredict_out = c1 & e1.mispredict;
        commit1_is_halt_out    = c1 & e1.halt;
        commit1_is_illegal_out = c1 & e1.illegal;
        commit1_arn_dest_out   = c1 ? e1.arn : 5'd0;
        commit1_prn_dest_out   = c1 ? e1.prn : '0;
        commit2_valid          = c2;
        commit2_if_rename_out  = c2;
        commit2_is_thread1     = c2 & sel_t1;
        commit2_pc_out         = c2 ? e2.pc : 64'd0;
        commit2_target_pc_out  = c2 ? e2.target_pc : 64'd0;
        commit2_is_branch_out  = c2 & e2.branch;
        commit2_mispredict_out = c2 & e2.mispredict;
        commit2_is_halt_out    = c2 & e2.halt;
        commit2_is_illegal_out = c2 & e2.illegal;
        commit2_arn_dest_out   = c2 ? e2.arn : 5'd0;
        commit2_prn_dest_out   = c2 ? e2.prn : '0;
    end

    rob_thread_queue #(.THREAD_ID(1'b0)) u_thread1 (
        .clock            (clock),
        .reset            (reset),
        .alloc1           (t1_alloc1),
        .alloc2           (t1_alloc2),
        .new1             (new1),
        .new2             (new2),
        .comp1_valid      (if_fu_executed1),
        .comp1_idx        (fu_rob_idx1),
        .comp1_mispredict (mispredict_in1),
        .comp1_target     (target_pc_in1),
        .comp2_valid      (if_fu_executed2),
        .comp2_idx        (fu_rob_idx2),
        .comp2_mispredict (mispredict_in2),
        .comp2_target     (target_pc_in2),
        .retire_cnt       (t1_retire),
        .flush            (t1_flush),
        .tail             (t1_tail),
        .is_full          (t1_is_full),
        .head_entry       (t1_head),
        .next_entry       (t1_next)
    );

    rob_thread_queue #(.THREAD_ID(1'b1)) u_thread2 (
        .clock            (clock),
        .reset            (reset),
        .alloc1           (t2_alloc1),
        .alloc2           (t2_alloc2),
        .new1             (new1),
        .new2             (new2),
        .comp1_valid      (if_fu_executed1),
        .comp1_idx        (fu_rob_idx1),
        .comp1_mispredict (mispredict_in1),
        .comp1_target     (target_pc_in1),
        .comp2_valid      (if_fu_executed2),
        .comp2_idx        (fu_rob_idx2),
        .comp2_mispredict (mispredict_in2),
        .comp2_target     (target_pc_in2),
        .retire_cnt       (t2_retire),
        .flush            (t2_flush),
        .tail             (t2_tail),
        .is_full          (t2_is_full),
        .head_entry       (t2_head),
        .next_entry       (t2_next)
    );

`ifdef ROB_ASSERT_EN
    // Protocol checks on dispatch and completion handshakes.
    always @(posedge clock) begin
        if (!reset) begin
            assert (!((inst1_load_in || inst2_load_in) && !load_ok))
                else $error("load while selected thread is full");
            assert (!$isunknown({inst1_load_in, inst2_load_in, if_fu_executed1, if_fu_executed2,
                                 commit1_valid, commit2_valid}))
                else $error("X on load/valid signal");
        end
    end
`else
`endif

endmodule

// File: tb/tb_rob_smt2.sv
// Self-checking bench for rob_smt2: directed scenarios plus random traffic vs a queue model.
module tb_rob_smt2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        is_thread1;
    logic [63:0] inst1_pc_in, inst2_pc_in;
    logic [4:0]  inst1_arn_dest_in, inst2_arn_dest_in;
    logic [5:0]  inst1_prn_dest_in, inst2_prn_dest_in;
    logic        inst1_is_branch_in, inst1_is_halt_in, inst1_is_illegal_in, inst1_load_in;
    logic        inst2_is_branch_in, inst2_is_halt_in, inst2_is_illegal_in, inst2_load_in;
    logic        if_fu_executed1, if_fu_executed2, mispredict_in1, mispredict_in2;
    logic [4:0]  fu_rob_idx1, fu_rob_idx2;
    logic [63:0] target_pc_in1, target_pc_in2;
    logic [4:0]  inst1_rs_rob_idx_in, inst2_rs_rob_idx_in;
    logic [63:0] commit1_pc_out, commit1_target_pc_out, commit2_pc_out, commit2_target_pc_out;
    logic        commit1_is_branch_out, commit1_mispredict_out, commit1_is_halt_out;
    logic        commit1_is_illegal_out, commit1_if_rename_out, commit1_valid, commit1_is_thread1;
    logic        commit2_is_branch_out, commit2_mispredict_out, commit2_is_halt_out;
    logic        commit2_is_illegal_out, commit2_if_rename_out, commit2_valid, commit2_is_thread1;
    logic [4:0]  commit1_arn_dest_out, commit2_arn_dest_out;
    logic [5:0]  commit1_prn_dest_out, commit2_prn_dest_out;
    logic        t1_is_full, t2_is_full;

    rob_smt2 dut (
        .clock(clock), .reset(reset), .is_thread1(is_thread1),
        .inst1_pc_in(inst1_pc_in), .inst1_arn_dest_in(inst1_arn_dest_in),
        .inst1_prn_dest_in(inst1_prn_dest_in), .inst1_is_branch_in(inst1_is_branch_in),
        .inst1_is_halt_in(inst1_is_halt_in), .inst1_is_illegal_in(inst1_is_illegal_in),
        .inst1_load_in(inst1_load_in),
        .inst2_pc_in(inst2_pc_in), .inst2_arn_dest_in(inst2_arn_dest_in),
        .inst2_prn_dest_in(inst2_prn_dest_in), .inst2_is_branch_in(inst2_is_branch_in),
        .inst2_is_halt_in(inst2_is_halt_in), .inst2_is_illegal_in(inst2_is_illegal_in),
        .inst2_load_in(inst2_load_in),
        .if_fu_executed1(if_fu_executed1), .fu_rob_idx1(fu_rob_idx1),
        .mispredict_in1(mispredict_in1), .target_pc_in1(target_pc_in1),
        .if_fu_executed2(if_fu_executed2), .fu_rob_idx2(fu_rob_idx2),
        .mispredict_in2(mispredict_in2), .target_pc_in2(target_pc_in2),
        .inst1_rs_rob_idx_in(inst1_rs_rob_idx_in), .inst2_rs_rob_idx_in(inst2_rs_rob_idx_in),
        .commit1_pc_out(commit1_pc_out), .commit1_target_pc_out(commit1_target_pc_out),
        .commit1_is_branch_out(commit1_is_branch_out),
        .commit1_mispredict_out(commit1_mispredict_out),
        .commit1_is_halt_out(commit1_is_halt_out), .commit1_is_illegal_out(commit1_is_illegal_out),
        .commit1_arn_dest_out(commit1_arn_dest_out), .commit1_prn_dest_out(commit1_prn_dest_out),
        .commit1_if_rename_out(commit1_if_rename_out), .commit1_valid(commit1_valid),
        .commit1_is_thread1(commit1_is_thread1),
        .commit2_pc_out(commit2_pc_out), .commit2_target_pc_out(commit2_target_pc_out),
        .commit2_is_branch_out(commit2_is_branch_out),
        .commit2_mispredict_out(commit2_mispredict_out),
        .commit2_is_halt_out(commit2_is_halt_out), .commit2_is_illegal_out(commit2_is_illegal_out),
        .commit2_arn_dest_out(commit2_arn_dest_out), .commit2_prn_dest_out(commit2_prn_dest_out),
        .commit2_if_rename_out(commit2_if_rename_out), .commit2_valid(commit2_valid),
        .commit2_is_thread1(commit2_is_thread1),
        .t1_is_full(t1_is_full), .t2_is_full(t2_is_full)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: per thread, an in-order list of live instructions plus the slot of the oldest.
    typedef struct {
        bit [63:0] pc;
        bit [63:0] tgt;
        bit [4:0]  arn;
        bit [5:0]  prn;
        bit        br, mp, halt, ill, exe;
    } m_ent_t;

    m_ent_t mq [2][$];
    int     mhead [2];

    function automatic m_ent_t mk(input logic [63:0] pc, input logic [4:0] arn,
                                  input logic [5:0] prn, input logic br, input logic halt,
                                  input logic ill);
        m_ent_t e;
        e.pc = pc; e.arn = arn; e.prn = prn; e.br = br; e.halt = halt; e.ill = ill;
        e.exe = halt | ill;
        return e;
    endfunction

    task automatic apply_comp(input logic v, input logic [4:0] idx, input logic mp,
                              input logic [63:0] tgt);
        int t, k;
        m_ent_t e;
        t = int'(idx[4]);
        k = (int'(idx[3:0]) - mhead[t] + 16) % 16;
        if (v && k < mq[t].size()) begin
            e = mq[t][k];
            e.exe = 1'b1; e.mp = mp; e.tgt = tgt;
            mq[t][k] = e;
        end
    endtask

    task automatic clear_inputs();
        is_thread1 = 1'b1;
        inst1_pc_in = '0; inst1_arn_dest_in = '0; inst1_prn_dest_in = '0;
        inst1_is_branch_in = 0; inst1_is_halt_in = 0; inst1_is_illegal_in = 0; inst1_load_in = 0;
        inst2_pc_in = '0; inst2_arn_dest_in = '0; inst2_prn_dest_in = '0;
        inst2_is_branch_in = 0; inst2_is_halt_in = 0; inst2_is_illegal_in = 0; inst2_load_in = 0;
        if_fu_executed1 = 0; fu_rob_idx1 = '0; mispredict_in1 = 0; target_pc_in1 = '0;
        if_fu_executed2 = 0; fu_rob_idx2 = '0; mispredict_in2 = 0; target_pc_in2 = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clock);
        mq[0].delete();
        mq[1].delete();
        mhead[0] = 0;
        mhead[1] = 0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic disp(input bit thr1, input bit v1, input logic [63:0] p1, input bit b1,
                        input bit h1, input bit v2, input logic [63:0] p2, input bit b2,
                        input bit h2);
        is_thread1 = thr1;
        inst1_load_in = v1; inst1_pc_in = p1; inst1_is_branch_in = b1; inst1_is_halt_in = h1;
        inst1_is_illegal_in = 0;
        inst1_arn_dest_in = 5'($urandom); inst1_prn_dest_in = 6'($urandom);
        inst2_load_in = v2; inst2_pc_in = p2; inst2_is_branch_in = b2; inst2_is_halt_in = h2;
        inst2_is_illegal_in = 0;
        inst2_arn_dest_in = 5'($urandom); inst2_prn_dest_in = 6'($urandom);
    endtask

    // Compare every output against the model, then advance the model across one clock edge.
    task automatic step();
        int     sel, tl, tail;
        bit     c1, c2, fl;
        bit     full_pre [2];
        m_ent_t e1, e2;
        logic [4:0] x1, x2;
        #1;
        sel = -1;
        if (mq[0].size() > 0 && mq[0][0].exe) sel = 0;
        else if (mq[1].size() > 0 && mq[1][0].exe) sel = 1;
        c1 = (sel >= 0);
        if (c1) begin
            e1 = mq[sel][0];
            c2 = mq[sel].size() > 1 && mq[sel][1].exe && !(e1.halt || e1.ill || (e1.br && e1.mp));
            if (c2) e2 = mq[sel][1];
        end
        tl   = is_thread1 ? 0 : 1;
        tail = (mhead[tl] + mq[tl].size()) % 16;
        x1   = {tl[0], 4'(tail)};
        x2   = {tl[0], 4'((inst1_load_in || !inst2_load_in) ? tail + 1 : tail)};
        check("idx1", 64'(inst1_rs_rob_idx_in), 64'(x1));
        check("idx2", 64'(inst2_rs_rob_idx_in), 64'(x2));
        check("full", 64'({t1_is_full, t2_is_full}),
              64'({mq[0].size() >= 15, mq[1].size() >= 15}));
        check("c1_valid", 64'(commit1_valid), 64'(c1));
        check("c1_pc", commit1_pc_out, e1.pc);
        check("c1_target", commit1_target_pc_out, e1.tgt);
        check("c1_flags", 64'({commit1_is_thread1, commit1_is_branch_out, commit1_mispredict_out,
                               commit1_is_halt_out, commit1_is_illegal_out, commit1_if_rename_out}),
              64'({c1 && sel == 0, e1.br, e1.mp, e1.halt, e1.ill, c1}));
        check("c1_dest", 64'({commit1_arn_dest_out, commit1_prn_dest_out}), 64'({e1.arn, e1.prn}));
        check("c2_valid", 64'(commit2_valid), 64'(c2));
        check("c2_pc", commit2_pc_out, e2.pc);
        check("c2_target", commit2_target_pc_out, e2.tgt);
        check("c2_flags", 64'({commit2_is_thread1, commit2_is_branch_out, commit2_mispredict_out,
                               commit2_is_halt_out, commit2_is_illegal_out, commit2_if_rename_out}),
              64'({c2 && sel == 0, e2.br, e2.mp, e2.halt, e2.ill, c2}));
        check("c2_dest", 64'({commit2_arn_dest_out, commit2_prn_dest_out}), 64'({e2.arn, e2.prn}));

        @(posedge clock);
        full_pre[0] = mq[0].size() >= 15;
        full_pre[1] = mq[1].size() >= 15;
        apply_comp(if_fu_executed1, fu_rob_idx1, mispredict_in1, target_pc_in1);
        apply_comp(if_fu_executed2, fu_rob_idx2, mispredict_in2, target_pc_in2);
        if (c1) begin void'(mq[sel].pop_front()); mhead[sel] = (mhead[sel] + 1) % 16; end
        if (c2) begin void'(mq[sel].pop_front()); mhead[sel] = (mhead[sel] + 1) % 16; end
        fl = c1 && ((e1.br && e1.mp) || (c2 && e2.br && e2.mp));
        if (fl) begin mq[sel].delete(); mhead[sel] = 0; end
        if (!full_pre[tl] && !(fl && sel == tl)) begin
            if (inst1_load_in)
                mq[tl].push_back(mk(inst1_pc_in, inst1_arn_dest_in, inst1_prn_dest_in,
                                    inst1_is_branch_in, inst1_is_halt_in, inst1_is_illegal_in));
            if (inst2_load_in)
                mq[tl].push_back(mk(inst2_pc_in, inst2_arn_dest_in, inst2_prn_dest_in,
                                    inst2_is_branch_in, inst2_is_halt_in, inst2_is_illegal_in));
        end
        @(negedge clock);
    endtask

    task automatic pick_fu(output logic v, output logic [4:0] idx, output logic mp,
                           output logic [63:0] tgt);
        int t, k;
        v   = ($urandom % 10) < 6;
        t   = int'($urandom % 2);
        tgt = {$urandom, $urandom};
        mp  = 1'b0;
        if (mq[t].size() > 0 && ($urandom % 10) < 9) begin
            k   = int'($urandom % mq[t].size());
            idx = {t[0], 4'((mhead[t] + k) % 16)};
            mp  = mq[t][k].br && ($urandom % 4 == 0);
        end else begin
            idx = 5'($urandom);
        end
    endtask

    initial begin
        clear_inputs();
        do_reset();

        // Halt + branch dispatch, halt retires alone the next cycle.
        disp(1, 1, 64'd4, 0, 1, 1, 64'd8, 1, 0);
        inst1_arn_dest_in = 5'd1; inst1_prn_dest_in = 6'd1;
        #1;
        check("t1_first_idx1", 64'(inst1_rs_rob_idx_in), 64'd0);
        check("t1_first_idx2", 64'(inst2_rs_rob_idx_in), 64'd1);
        step();
        clear_inputs();
        #1;
        check("halt_c1_valid", 64'(commit1_valid), 64'd1);
        check("halt_c1_pc", commit1_pc_out, 64'd4);
        check("halt_c1_halt", 64'(commit1_is_halt_out), 64'd1);
        check("halt_c2_valid", 64'(commit2_valid), 64'd0);
        step();

        // Pair at idx 2,3; complete out of order, both retire together.
        disp(1, 1, 64'd12, 1, 0, 1, 64'd16, 0, 0);
        step();
        clear_inputs();
        if_fu_executed1 = 1; fu_rob_idx1 = 5'd1;
        if_fu_executed2 = 1; fu_rob_idx2 = 5'd3;
        step();
        clear_inputs();
        if_fu_executed1 = 1; fu_rob_idx1 = 5'd2;
        step();
        clear_inputs();
        #1;
        check("pair_c1_pc", commit1_pc_out, 64'd12);
        check("pair_c1_branch", 64'(commit1_is_branch_out), 64'd1);
        check("pair_c2_pc", commit2_pc_out, 64'd16);
        step();

        // Mispredicted branch flushes thread1; same-cycle dispatch is dropped.
        do_reset();
        disp(1, 1, 64'h40, 1, 0, 1, 64'h44, 0, 1);
        step();
        clear_inputs();
        if_fu_executed1 = 1; fu_rob_idx1 = 5'd0; mispredict_in1 = 1; target_pc_in1 = 64'd100;
        step();
        clear_inputs();
        #1;
        check("mp_c1_mispredict", 64'(commit1_mispredict_out), 64'd1);
        check("mp_c1_target", commit1_target_pc_out, 64'd100);
        check("mp_c2_valid", 64'(commit2_valid), 64'd0);
        disp(1, 1, 64'h80, 0, 0, 1, 64'h84, 0, 0);
        step();
        disp(1, 1, 64'h90, 0, 0, 1, 64'h94, 0, 0);
        #1;
        check("post_flush_idx1", 64'(inst1_rs_rob_idx_in), 64'd0);
        check("post_flush_idx2", 64'(inst2_rs_rob_idx_in), 64'd1);
        step();

        // Fill thread1 to 15 entries; thread2 still dispatches.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            disp(1, 1, 64'(i * 8), 0, 0, 1, 64'(i * 8 + 4), 0, 0);
            step();
        end
        disp(1, 1, 64'h100, 0, 0, 0, 64'd0, 0, 0);
        step();
        disp(1, 1, 64'h200, 0, 0, 1, 64'h204, 0, 0);
        #1;
        check("t1_full", 64'(t1_is_full), 64'd1);
        step();
        disp(0, 1, 64'h300, 0, 0, 1, 64'h304, 0, 0);
        #1;
        check("t2_idx1", 64'(inst1_rs_rob_idx_in), 64'd16);
        check("t2_idx2", 64'(inst2_rs_rob_idx_in), 64'd17);
        step();

        // Both heads ready: thread1 first, thread2 the next cycle.
        do_reset();
        disp(1, 1, 64'h500, 0, 0, 1, 64'h504, 0, 0);
        step();
        disp(0, 1, 64'h600, 0, 0, 1, 64'h604, 0, 0);
        step();
        clear_inputs();
        if_fu_executed1 = 1; fu_rob_idx1 = 5'd0;
        if_fu_executed2 = 1; fu_rob_idx2 = 5'd16;
        step();
        clear_inputs();
        #1;
        check("prio_t1_valid", 64'(commit1_valid), 64'd1);
        check("prio_t1_thread", 64'(commit1_is_thread1), 64'd1);
        step();
        #1;
        check("prio_t2_valid", 64'(commit1_valid), 64'd1);
        check("prio_t2_thread", 64'(commit1_is_thread1), 64'd0);
        step();

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            disp(1'($urandom), ($urandom % 10) < 7, {$urandom, $urandom}, ($urandom % 4) == 0,
                 ($urandom % 16) == 0, ($urandom % 10) < 7, {$urandom, $urandom},
                 ($urandom % 4) == 0, ($urandom % 16) == 0);
            inst1_is_illegal_in = ($urandom % 20) == 0;
            inst2_is_illegal_in = ($urandom % 20) == 0;
            pick_fu(if_fu_executed1, fu_rob_idx1, mispredict_in1, target_pc_in1);
            pick_fu(if_fu_executed2, fu_rob_idx2, mispredict_in2, target_pc_in2);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
